// File: rtl/tcdm_addr_decoder.sv
// ----------------------------------------------------------------------------
// Module      : tcdm_addr_decoder
// Description : Zero-latency TCDM address decoder with an error plug and
//               per-target outstanding tracking.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tcdm_addr_decoder #(
  parameter int NB_SLAVES       = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  // master side
  input  logic                                  m_req,
  input  logic [ADDR_WIDTH-1:0]                 m_add,
  input  logic                                  m_wen,
  input  logic [DATA_WIDTH-1:0]                 m_wdata,
  input  logic [DATA_WIDTH/8-1:0]               m_be,
  output logic                                  m_gnt,
  output logic [DATA_WIDTH-1:0]                 m_r_rdata,
  output logic                                  m_r_opc,
  output logic                                  m_r_valid,
  // target side
  output logic [NB_SLAVES-1:0]                  s_req,
  output logic [ADDR_WIDTH-1:0]                 s_add,
  output logic                                  s_wen,
  output logic [DATA_WIDTH-1:0]                 s_wdata,
  output logic [DATA_WIDTH/8-1:0]               s_be,
  input  logic [NB_SLAVES-1:0]                  s_gnt,
  input  logic [NB_SLAVES-1:0][DATA_WIDTH-1:0]  s_r_rdata,
  input  logic [NB_SLAVES-1:0]                  s_r_opc,
  input  logic [NB_SLAVES-1:0]                  s_r_valid,
  // error plug
  output logic                                  e_req,
  output logic [ADDR_WIDTH-1:0]                 e_add,
  output logic                                  e_wen,
  output logic [DATA_WIDTH-1:0]                 e_wdata,
  output logic [DATA_WIDTH/8-1:0]               e_be,
  input  logic                                  e_gnt,
  input  logic [DATA_WIDTH-1:0]                 e_r_rdata,
  input  logic                                  e_r_opc,
  input  logic                                  e_r_valid,
  // address map and error status
  input  logic [NB_SLAVES-1:0][ADDR_WIDTH-1:0]  i_start_addr,
  input  logic [NB_SLAVES-1:0][ADDR_WIDTH-1:0]  i_end_addr,
  input  logic                                  i_err_clr,
  output logic [15:0]                           o_err_cnt,
  output logic [ADDR_WIDTH-1:0]                 o_err_addr,
  output logic                                  o_err_irq
);

  localparam int                 c_IDX_W   = $clog2(NB_SLAVES + 1);
  localparam int                 c_CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_IDX_W-1:0] c_ERR_IDX = c_IDX_W'(NB_SLAVES);
  localparam logic [c_CNT_W-1:0] c_MAX     = c_CNT_W'(MAX_OUTSTANDING);
  localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

  logic [c_CNT_W-1:0]                 r_cnt;
  logic [c_IDX_W-1:0]                 r_cur;
  logic [15:0]                        r_err_cnt;
  logic [ADDR_WIDTH-1:0]              r_err_addr;
  logic                               r_err_irq;

  logic [c_IDX_W-1:0]                 w_sel;
  logic                               w_permit;
  logic                               w_hs;
  logic                               w_err_hs;
  logic [NB_SLAVES:0]                 w_req_all;
  logic [NB_SLAVES:0]                 w_gnt_all;
  logic [NB_SLAVES:0]                 w_rv_all;
  logic [NB_SLAVES:0]                 w_opc_all;
  logic [NB_SLAVES:0][DATA_WIDTH-1:0] w_rdata_all;

  // Destination NB_SLAVES is the error plug in all the merged vectors.
  assign w_gnt_all   = {e_gnt, s_gnt};
  assign w_rv_all    = {e_r_valid, s_r_valid};
  assign w_opc_all   = {e_r_opc, s_r_opc};
  assign w_rdata_all = {e_r_rdata, s_r_rdata};

  // Descending scan so the lowest matching region is the last one assigned.
  always_comb begin
    w_sel = c_ERR_IDX;
    for (int k = NB_SLAVES - 1; k >= 0; k--) begin
      if ((m_add >= i_start_addr[k]) && (m_add < i_end_addr[k])) begin
        w_sel = c_IDX_W'(k);
      end
    end
  end

  // Outstanding requests must all target one destination so responses stay ordered.
  assign w_permit = i_rst_n && (r_cnt < c_MAX) && ((r_cnt == '0) || (w_sel == r_cur));
  assign m_gnt    = w_permit & w_gnt_all[w_sel];
  assign w_hs     = m_req & m_gnt;
  assign w_err_hs = w_hs && (w_sel == c_ERR_IDX);

  for (genvar k = 0; k <= NB_SLAVES; k++) begin : g_req
    assign w_req_all[k] = m_req & w_permit & (w_sel == c_IDX_W'(k));
  end

  assign s_req   = w_req_all[NB_SLAVES-1:0];
  assign e_req   = w_req_all[NB_SLAVES];
  assign s_add   = m_add;
  assign s_wen   = m_wen;
  assign s_wdata = m_wdata;
  assign s_be    = m_be;
  assign e_add   = m_add;
  assign e_wen   = m_wen;
  assign e_wdata = m_wdata;
  assign e_be    = m_be;

  assign m_r_valid = i_rst_n && (r_cnt != '0) && w_rv_all[r_cur];
  assign m_r_rdata = w_rdata_all[r_cur];
  assign m_r_opc   = w_opc_all[r_cur];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_cur <= c_ERR_IDX;
    end else begin
      if (w_hs && !m_r_valid) begin
        r_cnt <= r_cnt + c_ONE;
      end else if (!w_hs && m_r_valid) begin
        r_cnt <= r_cnt - c_ONE;
      end
      if (w_hs) begin
        r_cur <= w_sel;
      end
    end
  end

  // A new miss takes priority over a coincident clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_cnt  <= '0;
      r_err_addr <= '0;
      r_err_irq  <= 1'b0;
    end else if (w_err_hs) begin
      r_err_irq <= 1'b1;
      if (i_err_clr) begin
        r_err_cnt  <= 16'd1;
        r_err_addr <= m_add;
      end else begin
        if (r_err_cnt != 16'hFFFF) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
        if (!r_err_irq) begin
          r_err_addr <= m_add;
        end
      end
    end else if (i_err_clr) begin
      r_err_cnt  <= '0;
      r_err_addr <= '0;
      r_err_irq  <= 1'b0;
    end
  end

  assign o_err_cnt  = r_err_cnt;
  assign o_err_addr = r_err_addr;
  assign o_err_irq  = r_err_irq;

endmodule

`default_nettype wire

// File: tb/tb_tcdm_addr_decoder.sv
// ----------------------------------------------------------------------------
// Module      : tb_tcdm_addr_decoder
// Description : Randomized and directed bench for tcdm_addr_decoder.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tcdm_addr_decoder;

  localparam int NB  = 2;
  localparam int MAX = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic                   clk;
  logic                   i_rst_n;
  logic                   m_req, m_wen, m_gnt, m_r_opc, m_r_valid;
  logic [AW-1:0]          m_add;
  logic [DW-1:0]          m_wdata, m_r_rdata;
  logic [DW/8-1:0]        m_be;
  logic [NB-1:0]          s_req, s_gnt, s_r_opc, s_r_valid;
  logic [AW-1:0]          s_add;
  logic                   s_wen;
  logic [DW-1:0]          s_wdata;
  logic [DW/8-1:0]        s_be;
  logic [NB-1:0][DW-1:0]  s_r_rdata;
  logic                   e_req, e_wen, e_gnt, e_r_opc, e_r_valid;
  logic [AW-1:0]          e_add;
  logic [DW-1:0]          e_wdata, e_r_rdata;
  logic [DW/8-1:0]        e_be;
  logic [NB-1:0][AW-1:0]  i_start_addr, i_end_addr;
  logic                   i_err_clr;
  logic [15:0]            o_err_cnt;
  logic [AW-1:0]          o_err_addr;
  logic                   o_err_irq;

  // The error plug always answers with this fixed error response.
  assign e_r_rdata = 32'hDEADBEEF;
  assign e_r_opc   = 1'b1;

  tcdm_addr_decoder #(
    .NB_SLAVES(NB), .MAX_OUTSTANDING(MAX), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .m_req(m_req), .m_add(m_add), .m_wen(m_wen), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_r_rdata(m_r_rdata), .m_r_opc(m_r_opc), .m_r_valid(m_r_valid),
    .s_req(s_req), .s_add(s_add), .s_wen(s_wen), .s_wdata(s_wdata), .s_be(s_be),
    .s_gnt(s_gnt), .s_r_rdata(s_r_rdata), .s_r_opc(s_r_opc), .s_r_valid(s_r_valid),
    .e_req(e_req), .e_add(e_add), .e_wen(e_wen), .e_wdata(e_wdata), .e_be(e_be),
    .e_gnt(e_gnt), .e_r_rdata(e_r_rdata), .e_r_opc(e_r_opc), .e_r_valid(e_r_valid),
    .i_start_addr(i_start_addr), .i_end_addr(i_end_addr), .i_err_clr(i_err_clr),
    .o_err_cnt(o_err_cnt), .o_err_addr(o_err_addr), .o_err_irq(o_err_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: destinations of requests still awaiting a response, oldest first.
  int          out_q[$];
  logic [15:0] e_cnt;
  logic [31:0] e_addr;
  logic        e_irq;

  logic [31:0] addr_pool [10] = '{32'h0000_0FFF, 32'h0000_1000, 32'h0000_1004, 32'h0000_1FFF,
                                  32'h0000_2000, 32'h0000_2FFC, 32'h0000_2FFF, 32'h0000_3000,
                                  32'h0000_8000, 32'h0000_3800};

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_dest(input logic [31:0] a);
    for (int k = 0; k < NB; k++) begin
      if (a >= i_start_addr[k] && a < i_end_addr[k]) return k;
    end
    return NB;
  endfunction

  function automatic logic gnt_of(input int d);
    return (d < NB) ? s_gnt[d] : e_gnt;
  endfunction

  function automatic logic rv_of(input int d);
    return (d < NB) ? s_r_valid[d] : e_r_valid;
  endfunction

  function automatic logic [31:0] rdata_of(input int d);
    return (d < NB) ? s_r_rdata[d] : e_r_rdata;
  endfunction

  function automatic logic opc_of(input int d);
    return (d < NB) ? s_r_opc[d] : e_r_opc;
  endfunction

  task automatic set_rv(input int d, input bit v);
    if (d < NB) s_r_valid[d] = v;
    else        e_r_valid = v;
  endtask

  task automatic mdl_reset();
    out_q.delete();
    e_cnt  = '0;
    e_addr = '0;
    e_irq  = 1'b0;
  endtask

  // Checks one cycle against the reference, advances the reference, returns 1 after the edge.
  task automatic step();
    int         sel;
    bit         permit, exp_gnt, exp_rv, hs;
    logic [NB:0] exp_req;
    #4;
    if (!i_rst_n) mdl_reset();
    sel    = ref_dest(m_add);
    permit = 1'b0;
    if (i_rst_n && out_q.size() < MAX) begin
      if (out_q.size() == 0) permit = 1'b1;
      else                   permit = (sel == out_q[0]);
    end
    exp_gnt = permit && gnt_of(sel);
    exp_req = '0;
    if (m_req && permit) exp_req[sel] = 1'b1;
    exp_rv = 1'b0;
    if (i_rst_n && out_q.size() > 0) exp_rv = rv_of(out_q[0]);
    check_val("req_vec", {e_req, s_req}, exp_req);
    check_val("m_gnt", m_gnt, exp_gnt);
    check_val("m_r_valid", m_r_valid, exp_rv);
    if (exp_rv) begin
      check_val("m_r_rdata", m_r_rdata, rdata_of(out_q[0]));
      check_val("m_r_opc", m_r_opc, opc_of(out_q[0]));
    end
    check_val("bcast", {s_add, e_add, s_wen, e_wen}, {m_add, m_add, m_wen, m_wen});
    check_val("bcast_wd", {s_wdata, e_wdata, s_be, e_be}, {m_wdata, m_wdata, m_be, m_be});
    check_val("err_cnt", o_err_cnt, e_cnt);
    check_val("err_addr", o_err_addr, e_addr);
    check_val("err_irq", o_err_irq, e_irq);
    if (i_rst_n) begin
      hs = m_req && exp_gnt;
      if (exp_rv) void'(out_q.pop_front());
      if (hs) out_q.push_back(sel);
      if (hs && sel == NB) begin
        if (i_err_clr) begin
          e_cnt  = 16'd1;
          e_addr = m_add;
        end else begin
          if (!e_irq) e_addr = m_add;
          if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
        end
        e_irq = 1'b1;
      end else if (i_err_clr) begin
        e_cnt  = '0;
        e_addr = '0;
        e_irq  = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    m_req = 1'b0; m_add = '0; m_wen = 1'b0; m_wdata = '0; m_be = '1;
    s_gnt = '1; e_gnt = 1'b1; s_r_valid = '0; e_r_valid = 1'b0;
    s_r_opc = '0; i_err_clr = 1'b0;
  endtask

  task automatic drain();
    quiet();
    for (int i = 0; i < 16 && out_q.size() > 0; i++) begin
      s_r_valid = '0; e_r_valid = 1'b0;
      set_rv(out_q[0], 1'b1);
      s_r_rdata[0] = $urandom; s_r_rdata[1] = $urandom;
      step();
    end
    check_val("drained", out_q.size(), 0);
    quiet();
  endtask

  task automatic rand_cycle(input int rsp_pct);
    int pick;
    m_req   = ($urandom_range(99) < 70);
    pick    = $urandom_range(10);
    m_add   = (pick == 10) ? ($urandom & 32'h0000_FFFF) : addr_pool[pick];
    m_wen   = $urandom_range(1);
    m_wdata = $urandom;
    m_be    = $urandom;
    s_gnt   = $urandom;
    e_gnt   = ($urandom_range(99) < 75);
    s_r_valid = '0; e_r_valid = 1'b0;
    for (int d = 0; d <= NB; d++) begin
      if (out_q.size() > 0) begin
        if (d == out_q[0]) set_rv(d, $urandom_range(99) < rsp_pct);
        else               set_rv(d, $urandom_range(99) < 15);
      end
    end
    s_r_rdata[0] = $urandom; s_r_rdata[1] = $urandom;
    s_r_opc   = $urandom;
    i_err_clr = ($urandom_range(99) < 5);
  endtask

  initial begin
    i_start_addr[0] = 32'h1000; i_end_addr[0] = 32'h2000;
    i_start_addr[1] = 32'h2000; i_end_addr[1] = 32'h3000;
    s_r_rdata = '0;
    quiet();
    mdl_reset();
    i_rst_n = 1'b0;
    m_req = 1'b1; m_add = 32'h1000;
    #1;
    step();
    step();
    i_rst_n = 1'b1;
    quiet();

    // single read to t0, response next cycle, then immediate issue to t1
    m_req = 1'b1; m_add = 32'h1004;
    #2; check_val("d1_sreq", s_req, 2'b01); check_val("d1_gnt", m_gnt, 1'b1);
    step();
    m_req = 1'b0; s_r_valid[0] = 1'b1; s_r_rdata[0] = 32'h1234_5678;
    #2; check_val("d1_rdata", {m_r_valid, m_r_rdata}, {1'b1, 32'h1234_5678});
    step();
    s_r_valid = '0; m_req = 1'b1; m_add = 32'h2000;
    #2; check_val("d1_next_gnt", m_gnt, 1'b1);
    step();
    drain();

    // target switch must wait for the first target's response
    m_req = 1'b1; m_add = 32'h1000; step();
    m_add = 32'h2000;
    #2; check_val("d2_stall", {m_gnt, s_req}, 3'b000);
    step();
    s_r_valid[0] = 1'b1;
    #2; check_val("d2_stall_rsp", m_gnt, 1'b0);
    step();
    s_r_valid = '0;
    #2; check_val("d2_issue", {m_gnt, s_req}, 3'b110);
    step();
    drain();

    // full count stalls even with a coincident response
    m_req = 1'b1; m_add = 32'h1000;
    for (int i = 0; i < MAX; i++) step();
    #2; check_val("d3_full", m_gnt, 1'b0);
    step();
    s_r_valid[0] = 1'b1;
    #2; check_val("d3_full_rsp", m_gnt, 1'b0);
    step();
    s_r_valid = '0;
    #2; check_val("d3_after", m_gnt, 1'b1);
    step();
    drain();

    // unmapped accesses
    m_req = 1'b1; m_add = 32'h8000;
    #2; check_val("d4_ereq", {e_req, m_gnt}, 2'b11);
    step();
    check_val("d4_err", {o_err_cnt, o_err_addr, o_err_irq}, {16'd1, 32'h8000, 1'b1});
    m_req = 1'b0; e_r_valid = 1'b1;
    #2; check_val("d4_ersp", {m_r_valid, m_r_opc, m_r_rdata}, {2'b11, 32'hDEADBEEF});
    step();
    e_r_valid = 1'b0; m_req = 1'b1; m_add = 32'h9000; step();
    check_val("d4_err2", {o_err_cnt, o_err_addr}, {16'd2, 32'h8000});
    drain();
    m_req = 1'b1; m_add = 32'hA000; i_err_clr = 1'b1; step();
    check_val("d5_clr_miss", {o_err_cnt, o_err_addr, o_err_irq}, {16'd1, 32'hA000, 1'b1});
    drain();
    i_err_clr = 1'b1; step();
    check_val("d5_clr", {o_err_cnt, o_err_addr, o_err_irq}, 49'd0);
    quiet();

    // reset with requests in flight, then a late response
    m_req = 1'b1; m_add = 32'h1000;
    for (int i = 0; i < 3; i++) step();
    i_rst_n = 1'b0;
    #1; check_val("d6_rst_gnt", {m_gnt, s_req, e_req}, 4'b0000);
    step();
    i_rst_n = 1'b1; m_req = 1'b0; s_r_valid[0] = 1'b1;
    #2; check_val("d6_late_rv", m_r_valid, 1'b0);
    step();
    quiet();

    for (int i = 0; i < 1500; i++) begin rand_cycle(60); step(); end
    drain();
    for (int i = 0; i < 1000; i++) begin rand_cycle(20); step(); end
    drain();
    // overlapping regions: lowest index must win
    i_start_addr[0] = 32'h1000; i_end_addr[0] = 32'h3000;
    i_start_addr[1] = 32'h2000; i_end_addr[1] = 32'h4000;
    for (int i = 0; i < 1000; i++) begin rand_cycle(50); step(); end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
